// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the MULT/DIV unit and the control FSM that drives it.
package mult_div_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/mult_div_unit_div_step.sv
// One combinational restoring-divide step on unsigned magnitudes.
module mult_div_unit_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   partial,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH-1:0] diff;

  // partial < 2*divisor, so a successful subtract always fits in WIDTH bits
  always_comb begin
    q_bit    = (partial >= {1'b0, divisor});
    diff     = partial[WIDTH-1:0] - divisor;
    rem_next = q_bit ? diff : partial[WIDTH-1:0];
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed MULT (radix-2 Booth) / DIV (restoring) unit producing the HI/LO pair.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  state_t             state_reg;
  logic [CW-1:0]      count_reg;
  logic               op_reg;
  logic               dz_pending_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;
  logic               busy_reg, done_reg, div_zero_reg;
  logic [WIDTH-1:0]   mcand_reg;
  logic [2*WIDTH:0]   acc_reg;
  logic [WIDTH-1:0]   rem_reg, quo_reg, dvs_reg;
  logic               q_neg_reg, r_neg_reg;

  logic [WIDTH:0]     upper_ext, mcand_ext, booth_sum;
  logic [2*WIDTH:0]   booth_next;
  logic [WIDTH-1:0]   step_rem;
  logic               step_q;

  // Booth add is done one bit wider so subtracting -2^(W-1) cannot overflow
  always_comb begin
    upper_ext = {acc_reg[2*WIDTH], acc_reg[2*WIDTH:WIDTH+1]};
    mcand_ext = {mcand_reg[WIDTH-1], mcand_reg};
    booth_sum = upper_ext;
    case (acc_reg[1:0])
      2'b01:   booth_sum = upper_ext + mcand_ext;
      2'b10:   booth_sum = upper_ext - mcand_ext;
      default: booth_sum = upper_ext;
    endcase
    booth_next = {booth_sum, acc_reg[WIDTH:1]};
  end

  mult_div_unit_div_step #(.WIDTH(WIDTH)) u_div_step (
    .partial  ({rem_reg, quo_reg[WIDTH-1]}),
    .divisor  (dvs_reg),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      count_reg      <= '0;
      op_reg         <= OP_MULT;
      dz_pending_reg <= 1'b0;
      hi_reg         <= '0;
      lo_reg         <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      div_zero_reg   <= 1'b0;
      mcand_reg      <= '0;
      acc_reg        <= '0;
      rem_reg        <= '0;
      quo_reg        <= '0;
      dvs_reg        <= '0;
      q_neg_reg      <= 1'b0;
      r_neg_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            op_reg         <= op;
            mcand_reg      <= a;
            acc_reg        <= {{WIDTH{1'b0}}, b, 1'b0};
            rem_reg        <= '0;
            quo_reg        <= a[WIDTH-1] ? WIDTH'(0) - a : a;
            dvs_reg        <= b[WIDTH-1] ? WIDTH'(0) - b : b;
            q_neg_reg      <= a[WIDTH-1] ^ b[WIDTH-1];
            r_neg_reg      <= a[WIDTH-1];
            div_zero_reg   <= 1'b0;
            busy_reg       <= 1'b1;
            count_reg      <= CW'(WIDTH - 1);
            dz_pending_reg <= (op == OP_DIV) && (b == '0);
            if (op == OP_MULT)
              state_reg <= ST_MULT;
            else if (b == '0)
              state_reg <= ST_DONE;
            else
              state_reg <= ST_DIV;
          end
        end
        ST_MULT: begin
          acc_reg <= booth_next;
          if (count_reg == '0) state_reg <= ST_DONE;
          else                 count_reg <= count_reg - 1'b1;
        end
        ST_DIV: begin
          rem_reg <= step_rem;
          quo_reg <= {quo_reg[WIDTH-2:0], step_q};
          if (count_reg == '0) state_reg <= ST_DONE;
          else                 count_reg <= count_reg - 1'b1;
        end
        ST_DONE: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= ST_IDLE;
          if (dz_pending_reg) begin
            div_zero_reg <= 1'b1;
          end else if (op_reg == OP_MULT) begin
            hi_reg <= acc_reg[2*WIDTH:WIDTH+1];
            lo_reg <= acc_reg[WIDTH:1];
          end else begin
            // MIPS semantics: quotient truncates toward zero, remainder follows dividend
            lo_reg <= q_neg_reg ? WIDTH'(0) - quo_reg : quo_reg;
            hi_reg <= r_neg_reg ? WIDTH'(0) - rem_reg : rem_reg;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign hi       = hi_reg;
  assign lo       = lo_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign div_zero = div_zero_reg;

endmodule
